// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults,
// counter width and sync polarity encoding.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned SYNC_ACTIVE_LOW  = 0;
    localparam int unsigned SYNC_ACTIVE_HIGH = 1;

    // Pin level for a sync pulse given whether it is logically asserted.
    function automatic logic sync_level(input logic asserted, input int unsigned pol);
        return (pol == SYNC_ACTIVE_HIGH) ? asserted : ~asserted;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulus counter with enable, parameterised reset-load value, terminal-count flag
// and a look-ahead of the value it will take on the next enabled edge.
module wrap_counter #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned MODULUS   = 800,
    parameter int unsigned RESET_VAL = MODULUS - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] LOAD_VAL = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] count_q;

    assign at_max     = (count_q == MAX_VAL);
    assign count_next = at_max ? '0 : count_q + WIDTH'(1);
    assign count      = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= LOAD_VAL;
        end else if (en) begin
            count_q <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: h/v counters advanced by the pixel strobe, with registered
// sync, active-video and line/frame markers aligned to the counters they describe.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned SYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_pixStb,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_active,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_lineStart,
    output logic             o_frameStart,
    output logic             o_pixValid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] x_q, y_q, x_next, y_step, y_next;
    logic             h_tc, v_tc;

    logic active_d, hsync_d, vsync_d, line_start_d, frame_start_d;
    logic active_q, hsync_q, vsync_q, line_start_q, frame_start_q, pix_valid_q;

    wrap_counter #(
        .WIDTH    (CNT_W),
        .MODULUS  (H_TOTAL),
        .RESET_VAL(H_TOTAL - 1)
    ) u_h_cnt (
        .clk       (i_clk),
        .rst_n     (i_rstn),
        .en        (i_pixStb),
        .count     (x_q),
        .count_next(x_next),
        .at_max    (h_tc)
    );

    wrap_counter #(
        .WIDTH    (CNT_W),
        .MODULUS  (V_TOTAL),
        .RESET_VAL(V_TOTAL - 1)
    ) u_v_cnt (
        .clk       (i_clk),
        .rst_n     (i_rstn),
        .en        (i_pixStb & h_tc),
        .count     (y_q),
        .count_next(y_step),
        .at_max    (v_tc)
    );

    // Decode from the look-ahead position so flags land together with the counters.
    always_comb begin
        y_next        = h_tc ? y_step : y_q;
        active_d      = (x_next < H_ACT_END) && (y_next < V_ACT_END);
        hsync_d       = sync_level((x_next >= HS_START) && (x_next <= HS_END), SYNC_POL);
        vsync_d       = sync_level((y_next >= VS_START) && (y_next <= VS_END), SYNC_POL);
        line_start_d  = h_tc;
        frame_start_d = h_tc & v_tc;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            active_q      <= 1'b0;
            hsync_q       <= sync_level(1'b0, SYNC_POL);
            vsync_q       <= sync_level(1'b0, SYNC_POL);
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_valid_q   <= 1'b0;
        end else begin
            pix_valid_q <= i_pixStb;
            if (i_pixStb) begin
                active_q      <= active_d;
                hsync_q       <= hsync_d;
                vsync_q       <= vsync_d;
                line_start_q  <= line_start_d;
                frame_start_q <= frame_start_d;
            end else begin
                line_start_q  <= 1'b0;
                frame_start_q <= 1'b0;
            end
        end
    end

    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_active     = active_q;
    assign o_hsync      = hsync_q;
    assign o_vsync      = vsync_q;
    assign o_lineStart  = line_start_q;
    assign o_frameStart = frame_start_q;
    assign o_pixValid   = pix_valid_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a shrunken, active-high-sync
// instance so whole frames fit in a short run; both checked against a raster model.
module tb_vga_timing;

    typedef struct packed {
        int ha; int hfp; int hs; int hbp;
        int va; int vfp; int vs; int vbp;
        int pol;
    } cfg_t;

    localparam cfg_t CFG_D = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    localparam cfg_t CFG_S = '{8, 2, 3, 3, 6, 1, 2, 2, 1};
    localparam int S_FRAME = 16 * 11;

    logic clk, rst_n, stb, stb_s;
    logic [9:0] d_x, d_y, s_x, s_y;
    logic d_active, d_hsync, d_vsync, d_ls, d_fs, d_pv;
    logic s_active, s_hsync, s_vsync, s_ls, s_fs, s_pv;
    logic [26:0] obs_d, obs_s;
    int checks = 0;
    int errors = 0;
    int n_d = 0;
    int n_s = 0;

    assign obs_d = {d_x, d_y, d_active, d_hsync, d_vsync, d_ls, d_fs, d_pv};
    assign obs_s = {s_x, s_y, s_active, s_hsync, s_vsync, s_ls, s_fs, s_pv};

    vga_timing dut (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_pixStb    (stb),
        .o_x         (d_x),
        .o_y         (d_y),
        .o_active    (d_active),
        .o_hsync     (d_hsync),
        .o_vsync     (d_vsync),
        .o_lineStart (d_ls),
        .o_frameStart(d_fs),
        .o_pixValid  (d_pv)
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1)
    ) dut_s (
        .i_clk       (clk),
        .i_rstn      (rst_n),
        .i_pixStb    (stb_s),
        .o_x         (s_x),
        .o_y         (s_y),
        .o_active    (s_active),
        .o_hsync     (s_hsync),
        .o_vsync     (s_vsync),
        .o_lineStart (s_ls),
        .o_frameStart(s_fs),
        .o_pixValid  (s_pv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after n strobes since reset: strobe k (1-based) shows raster
    // position k-1 in row-major order; zero strobes shows the last blanking pixel.
    function automatic logic [26:0] model(input cfg_t c, input int n, input bit strobed);
        int ht = c.ha + c.hfp + c.hs + c.hbp;
        int vt = c.va + c.vfp + c.vs + c.vbp;
        int x, y, k;
        bit act, hsa, vsa, ls, fs, hl, vl;
        if (n == 0) begin
            x = ht - 1;
            y = vt - 1;
        end else begin
            k = (n - 1) % (ht * vt);
            x = k % ht;
            y = k / ht;
        end
        act = (x < c.ha) && (y < c.va);
        hsa = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hs);
        vsa = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vs);
        hl  = (c.pol == 1) ? hsa : !hsa;
        vl  = (c.pol == 1) ? vsa : !vsa;
        ls  = strobed && (x == 0);
        fs  = ls && (y == 0);
        return {10'(x), 10'(y), act, hl, vl, ls, fs, strobed};
    endfunction

    task automatic step(input bit sd, input bit ss);
        stb   = sd;
        stb_s = ss;
        @(posedge clk);
        #1;
        if (sd) n_d++;
        if (ss) n_s++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stb   = 1'b0;
        stb_s = 1'b0;
        @(posedge clk);
        #1;
        n_d   = 0;
        n_s   = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stb   = 1'b0;
        stb_s = 1'b0;
        n_d   = 0;
        n_s   = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({d_x, d_y, d_active, d_hsync, d_vsync, d_ls, d_fs, d_pv} !==
            {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL reset_held: got %h required %h", obs_d,
                     {10'd799, 10'd524, 7'b0110000});
        end
        checks++;
        if (obs_s !== model(CFG_S, 0, 1'b0)) begin
            errors++;
            $display("FAIL reset_held_small: got %h required %h", obs_s, model(CFG_S, 0, 1'b0));
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            checks++;
            if (obs_d !== model(CFG_D, 0, 1'b0)) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h required %h", i, obs_d,
                         model(CFG_D, 0, 1'b0));
            end
        end
    endtask

    task automatic test_strobe_every_4th();
        for (int c = 0; c < 3040; c++) begin
            bit s;
            s = (c % 4 == 0);
            step(s, 1'b0);
            checks++;
            if (obs_d !== model(CFG_D, n_d, s)) begin
                errors++;
                $display("FAIL strobe4 n=%0d: got %h required %h", n_d, obs_d, model(CFG_D, n_d, s));
            end
            if (s && n_d == 1) begin
                checks++;
                if ({d_x, d_y, d_active, d_ls, d_fs} !== {20'd0, 3'b111}) begin
                    errors++;
                    $display("FAIL first_strobe: got x=%0d y=%0d act=%b ls=%b fs=%b required 0 0 1 1 1",
                             d_x, d_y, d_active, d_ls, d_fs);
                end
            end
            if (!s && n_d == 1 && c == 1) begin
                checks++;
                if ({d_ls, d_fs} !== 2'b00) begin
                    errors++;
                    $display("FAIL pulse_width: got ls=%b fs=%b required 0 0", d_ls, d_fs);
                end
            end
            if (s && n_d == 657) begin
                checks++;
                if ({d_x, d_hsync} !== {10'd656, 1'b0}) begin
                    errors++;
                    $display("FAIL hsync_start: got x=%0d hs=%b required 656 0", d_x, d_hsync);
                end
            end
            if (s && n_d == 753) begin
                checks++;
                if ({d_x, d_hsync} !== {10'd752, 1'b1}) begin
                    errors++;
                    $display("FAIL hsync_end: got x=%0d hs=%b required 752 1", d_x, d_hsync);
                end
            end
        end
    endtask

    task automatic test_line_wrap();
        int gap = 0;
        while (n_d < 1700) begin
            bit s;
            s = (gap == 0);
            step(s, 1'b0);
            gap = s ? int'($urandom_range(0, 3)) : gap - 1;
            checks++;
            if (obs_d !== model(CFG_D, n_d, s)) begin
                errors++;
                $display("FAIL line_wrap n=%0d: got %h required %h", n_d, obs_d, model(CFG_D, n_d, s));
            end
            if (s && n_d == 641) begin
                checks++;
                if ({d_x, d_active} !== {10'd640, 1'b0}) begin
                    errors++;
                    $display("FAIL active_end: got x=%0d act=%b required 640 0", d_x, d_active);
                end
            end
            if (s && n_d == 801) begin
                checks++;
                if ({d_x, d_y, d_ls, d_fs} !== {10'd0, 10'd1, 2'b10}) begin
                    errors++;
                    $display("FAIL x_wrap: got x=%0d y=%0d ls=%b fs=%b required 0 1 1 0",
                             d_x, d_y, d_ls, d_fs);
                end
            end
        end
    endtask

    task automatic test_continuous();
        int last_fs = -1;
        int act_cnt = 0;
        int fs_cnt  = 0;
        do_reset();
        for (int c = 1; c <= 4 * S_FRAME + 2; c++) begin
            step(1'b0, 1'b1);
            checks++;
            if (obs_s !== model(CFG_S, n_s, 1'b1)) begin
                errors++;
                $display("FAIL continuous n=%0d: got %h required %h", n_s, obs_s,
                         model(CFG_S, n_s, 1'b1));
            end
            if (s_fs) begin
                fs_cnt++;
                if (last_fs >= 0) begin
                    checks++;
                    if (c - last_fs != S_FRAME) begin
                        errors++;
                        $display("FAIL frame_spacing: got %0d required %0d", c - last_fs, S_FRAME);
                    end
                    checks++;
                    if (act_cnt != 48) begin
                        errors++;
                        $display("FAIL active_count: got %0d required 48", act_cnt);
                    end
                end
                last_fs = c;
                act_cnt = 0;
            end
            if (s_active) act_cnt++;
        end
        checks++;
        if (fs_cnt != 5) begin
            errors++;
            $display("FAIL frame_starts: got %0d required 5", fs_cnt);
        end
    endtask

    task automatic test_gaps();
        int gap = 0;
        do_reset();
        while (n_s <= 2 * S_FRAME + 1) begin
            bit s;
            s = (gap == 0);
            step(1'b0, s);
            gap = s ? int'($urandom_range(1, 7)) : gap - 1;
            checks++;
            if (obs_s !== model(CFG_S, n_s, s)) begin
                errors++;
                $display("FAIL gaps n=%0d: got %h required %h", n_s, obs_s, model(CFG_S, n_s, s));
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 1; i <= 301; i++) step(1'b1, i > 301 - 49);
        checks++;
        if ({d_x, d_y, s_x, s_y, s_ls} !== {10'd300, 10'd0, 10'd0, 10'd3, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: got d=(%0d,%0d) s=(%0d,%0d) ls=%b required (300,0) (0,3) 1",
                     d_x, d_y, s_x, s_y, s_ls);
        end
        #1 rst_n = 1'b0;
        #1;
        n_d = 0;
        n_s = 0;
        checks++;
        if (obs_d !== model(CFG_D, 0, 1'b0)) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", obs_d, model(CFG_D, 0, 1'b0));
        end
        checks++;
        if (obs_s !== model(CFG_S, 0, 1'b0)) begin
            errors++;
            $display("FAIL async_reset_small: got %h required %h", obs_s, model(CFG_S, 0, 1'b0));
        end
        stb   = 1'b0;
        stb_s = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (obs_d !== model(CFG_D, 1, 1'b1)) begin
            errors++;
            $display("FAIL post_reset: got %h required %h", obs_d, model(CFG_D, 1, 1'b1));
        end
        checks++;
        if ({s_x, s_y, s_fs, s_ls} !== {20'd0, 2'b11}) begin
            errors++;
            $display("FAIL post_reset_small: got x=%0d y=%0d fs=%b ls=%b required 0 0 1 1",
                     s_x, s_y, s_fs, s_ls);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stb   = 1'b0;
        stb_s = 1'b0;
        test_reset();
        test_strobe_every_4th();
        test_line_wrap();
        test_continuous();
        test_gaps();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
